hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Sequences pipeline stalls and flushes for the 5-stage MIPS core.
- Sits in ID beside the forwarding unit. It detects load-use and branch-operand hazards that forwarding cannot cover, and holds PC and IF/ID for the required number of cycles.
- It inserts bubbles into ID/EX and flushes IF/ID on taken branches and jumps.
- A small FSM with a down-counter covers multi-cycle stalls.

Parameters:
- LB_STALLS, 2, stall cycles for a branch in ID whose operand is loaded by the instruction in ID/EX; legal range 1..3.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- ID_EX_RegWrite  input  1  instruction in EX writes a register.
- ID_EX_WriteReg  input  5  destination register of the EX instruction (Rt/Rd already muxed).
- EX_MEM_MemRead  input  1  instruction in MEM is a load.
- EX_MEM_WriteReg  input  5  destination register of the MEM instruction.
- IF_ID_RegisterRs  input  5  Rs of the instruction in ID.
- IF_ID_RegisterRt  input  5  Rt of the instruction in ID.
- IF_ID_UsesRt  input  1  ID instruction reads Rt (R-type, beq, bne, sw).
- beq, bne  input  1 each  ID instruction is a conditional branch.
- branch_taken  input  1  ID comparator result, valid when beq|bne.
- jump  input  1  ID instruction is j/jal.
- PCWrite  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID update enable.
- ID_EX_Bubble  output  1  zero the control signals entering ID/EX.
- IF_ID_Flush  output  1  clear IF/ID on the next edge.
- stall_active  output  1  high in every stalled cycle.

Behaviour:
- All outputs are combinational from the state and the inputs.
- Reset:
  - While rst=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, stall_active=0.
  - The FSM enters RUN with cnt=0 asynchronously.
- "match(r)": r!=0 and (r==IF_ID_RegisterRs or (IF_ID_UsesRt and r==IF_ID_RegisterRt)).
- Hazard classes, evaluated in RUN only:
  - H_LU (load-use): ID_EX_MemRead and match(ID_EX_WriteReg). Needs 1 stall.
  - H_BL (branch on a load in EX): (beq|bne) and ID_EX_MemRead and match(ID_EX_WriteReg). Needs LB_STALLS; takes priority over H_LU.
  - H_BA (branch on an ALU result in EX): (beq|bne) and ID_EX_RegWrite and !ID_EX_MemRead and match(ID_EX_WriteReg). Needs 1 stall.
  - H_BM (branch on a load in MEM): (beq|bne) and EX_MEM_MemRead and match(EX_MEM_WriteReg). Needs 1 stall.
- Stall cycle outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, stall_active=1.
- Normal cycle outputs: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, stall_active=0.
- FSM:
  - RUN, no hazard: normal cycle. IF_ID_Flush = jump or ((beq|bne) and branch_taken).
  - RUN, any hazard with need N: stall this cycle, no flush. If N>1, load cnt=N-1 and go to STALL; else remain in RUN and re-evaluate next cycle.
  - STALL: stall cycle unconditionally; inputs are ignored and cnt decrements. When cnt reaches 1 this cycle, return to RUN, which re-evaluates hazards and branch outcome.
- Boundary conditions:
  - Register 0 never matches.
  - Stall beats flush: a branch is never resolved or flushed in a stalled cycle.
  - jump never stalls.
  - Simultaneous H_BL and H_BM use max(need).
  - rst asserted mid-STALL aborts the stall immediately; cnt=0.
  - LB_STALLS=1 never enters STALL.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro:
  - Adds outputs stall_cycles[CNT_W-1:0] (+1 per stall_active cycle) and flush_count[CNT_W-1:0] (+1 per IF_ID_Flush cycle).
  - Both counters saturate at all-ones and clear on rst.
- Without the macro: neither port nor logic exists, and behaviour is otherwise identical.

Test Plan:
- lw $t0 in EX (ID_EX_MemRead=1, WriteReg=8), add $t1,$t0,$t2 in ID (Rs=8) -> exactly 1 cycle of PCWrite=0/IF_ID_Write=0/Bubble=1, then normal.
- lw $t0 in EX, beq $t0,$zero in ID, LB_STALLS=2 -> 2 consecutive stall cycles (STALL entered with cnt=1), then RUN; taken branch gives IF_ID_Flush=1 in the 3rd cycle.
- add $t3 in EX (RegWrite=1, MemRead=0, WriteReg=11), bne $t3,$t4 in ID -> 1 stall cycle; next cycle with branch_taken=1 -> IF_ID_Flush=1, PCWrite=1.
- Destination register 0 with MemRead=1, ID Rs=0 -> no stall; jump=1 -> IF_ID_Flush=1, no stall.
- rst pulsed during the 1st STALL cycle -> outputs take reset values immediately; after release, RUN with no residual stall (hazard inputs cleared).
- HAZARD_PERF_CNT_EN defined, the scenario-2 sequence run 3 times -> stall_cycles=6, flush_count=3.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-operand stall and flush sequencer for the 5-stage MIPS core.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
  parameter int LB_STALLS = 2,
  parameter int CNT_W     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID_EX_MemRead,
  input  logic       ID_EX_RegWrite,
  input  logic [4:0] ID_EX_WriteReg,
  input  logic       EX_MEM_MemRead,
  input  logic [4:0] EX_MEM_WriteReg,
  input  logic [4:0] IF_ID_RegisterRs,
  input  logic [4:0] IF_ID_RegisterRt,
  input  logic       IF_ID_UsesRt,
  input  logic       beq,
  input  logic       bne,
  input  logic       branch_taken,
  input  logic       jump,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       ID_EX_Bubble,
  output logic       IF_ID_Flush,
  output logic       stall_active
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] LB_NEED = 2'(LB_STALLS);

  state_t     r_state;
  logic [1:0] r_cnt;

  logic       w_branch;
  logic       w_match_ex;
  logic       w_match_mem;
  logic       w_h_lu;
  logic       w_h_bl;
  logic       w_h_ba;
  logic       w_h_bm;
  logic [1:0] w_need;
  logic       w_stall;

  function automatic logic match_id(input logic [4:0] r, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  always_comb begin
    w_branch    = beq | bne;
    w_match_ex  = match_id(ID_EX_WriteReg, IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt);
    w_match_mem = match_id(EX_MEM_WriteReg, IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt);
    w_h_lu      = ID_EX_MemRead & w_match_ex;
    w_h_bl      = w_branch & w_h_lu;
    w_h_ba      = w_branch & ID_EX_RegWrite & ~ID_EX_MemRead & w_match_ex;
    w_h_bm      = w_branch & EX_MEM_MemRead & w_match_mem;
    // H_BL dominates; LB_STALLS >= 1 so it is also the max when paired with H_BM.
    if (w_h_bl)
      w_need = LB_NEED;
    else if (w_h_lu | w_h_ba | w_h_bm)
      w_need = 2'd1;
    else
      w_need = 2'd0;
    w_stall = (r_state == STALL) || (w_need != 2'd0);
  end

  always_comb begin
    if (rst) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      IF_ID_Flush  = 1'b0;
      stall_active = 1'b0;
    end else if (w_stall) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      IF_ID_Flush  = 1'b0;
      stall_active = 1'b1;
    end else begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Bubble = 1'b0;
      IF_ID_Flush  = jump | (w_branch & branch_taken);
      stall_active = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_need > 2'd1) begin
            r_cnt   <= w_need - 2'd1;
            r_state <= STALL;
          end
        end
        STALL: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1)
            r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_active && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (IF_ID_Flush && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed pipeline scenarios plus random traffic
// compared every cycle against a remaining-stall-count model.
module tb_hazard_stall_controller;

  localparam int LB = 2;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ID_EX_MemRead = 1'b0, ID_EX_RegWrite = 1'b0;
  logic [4:0] ID_EX_WriteReg = '0;
  logic       EX_MEM_MemRead = 1'b0;
  logic [4:0] EX_MEM_WriteReg = '0;
  logic [4:0] IF_ID_RegisterRs = '0, IF_ID_RegisterRt = '0;
  logic       IF_ID_UsesRt = 1'b0;
  logic       beq = 1'b0, bne = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic       PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, stall_active;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  hazard_stall_controller #(.LB_STALLS(LB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_WriteReg(ID_EX_WriteReg),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_WriteReg(EX_MEM_WriteReg),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .IF_ID_UsesRt(IF_ID_UsesRt), .beq(beq), .bne(bne),
    .branch_taken(branch_taken), .jump(jump),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .stall_active(stall_active)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: number of stall cycles still owed after the current one, plus counters.
  int m_rem = 0;
  int m_sc = 0;
  int m_fc = 0;

  function automatic bit reads(input int r);
    return (r != 0) && (r == int'(IF_ID_RegisterRs) ||
                        (IF_ID_UsesRt && r == int'(IF_ID_RegisterRt)));
  endfunction

  function automatic int hazard_need();
    int n;
    bit br;
    n  = 0;
    br = beq || bne;
    if (ID_EX_MemRead && reads(ID_EX_WriteReg)) n = (n > 1) ? n : 1;
    if (br && ID_EX_MemRead && reads(ID_EX_WriteReg)) n = (n > LB) ? n : LB;
    if (br && ID_EX_RegWrite && !ID_EX_MemRead && reads(ID_EX_WriteReg)) n = (n > 1) ? n : 1;
    if (br && EX_MEM_MemRead && reads(EX_MEM_WriteReg)) n = (n > 1) ? n : 1;
    return n;
  endfunction

  always @(negedge clk) begin
    int e_pc, e_ifw, e_bub, e_fl, e_st, need;
    need = 0;
    if (rst) begin
      m_rem = 0; m_sc = 0; m_fc = 0;
      e_pc = 0; e_ifw = 0; e_bub = 1; e_fl = 0; e_st = 0;
    end else if (m_rem > 0) begin
      e_pc = 0; e_ifw = 0; e_bub = 1; e_fl = 0; e_st = 1;
    end else begin
      need = hazard_need();
      if (need > 0) begin
        e_pc = 0; e_ifw = 0; e_bub = 1; e_fl = 0; e_st = 1;
      end else begin
        e_pc = 1; e_ifw = 1; e_bub = 0; e_st = 0;
        e_fl = (jump || ((beq || bne) && branch_taken)) ? 1 : 0;
      end
    end
    chk("PCWrite", int'(PCWrite), e_pc);
    chk("IF_ID_Write", int'(IF_ID_Write), e_ifw);
    chk("ID_EX_Bubble", int'(ID_EX_Bubble), e_bub);
    chk("IF_ID_Flush", int'(IF_ID_Flush), e_fl);
    chk("stall_active", int'(stall_active), e_st);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", int'(stall_cycles), m_sc);
    chk("flush_count", int'(flush_count), m_fc);
`endif
    if (!rst) begin
      if (m_rem > 0) m_rem--;
      else if (need > 0) m_rem = need - 1;
      if (e_st == 1 && m_sc < (1 << CW) - 1) m_sc++;
      if (e_fl == 1 && m_fc < (1 << CW) - 1) m_fc++;
    end
  end

  task automatic to_drive(); @(posedge clk); #1; endtask
  task automatic to_check(); @(negedge clk); #1; endtask

  task automatic clear_in();
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_WriteReg = 0;
    EX_MEM_MemRead = 0; EX_MEM_WriteReg = 0;
    IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0; IF_ID_UsesRt = 0;
    beq = 0; bne = 0; branch_taken = 0; jump = 0;
  endtask

  task automatic load_branch();
    clear_in();
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_WriteReg = 8;
    beq = 1; IF_ID_RegisterRs = 8; IF_ID_RegisterRt = 0; IF_ID_UsesRt = 1;
    branch_taken = 1;
  endtask

  // lw $t0 in EX, beq $t0,$zero taken in ID: two stalls then flush.
  task automatic scen_load_branch();
    to_drive(); load_branch();
    to_check(); chk("lb_stall1", int'(stall_active), 1);
    to_drive(); clear_in(); EX_MEM_MemRead = 1; EX_MEM_WriteReg = 8;
    beq = 1; IF_ID_RegisterRs = 8; IF_ID_UsesRt = 1; branch_taken = 1;
    to_check(); chk("lb_stall2", int'(PCWrite), 0);
    to_drive(); clear_in(); beq = 1; IF_ID_RegisterRs = 8; IF_ID_UsesRt = 1; branch_taken = 1;
    to_check(); chk("lb_flush", int'(IF_ID_Flush), 1);
    chk("lb_pcwrite", int'(PCWrite), 1);
  endtask

  initial begin
    clear_in();
    rst = 1;
    to_check();
    chk("rst_bubble", int'(ID_EX_Bubble), 1);
    chk("rst_pcwrite", int'(PCWrite), 0);
    to_drive(); to_drive(); rst = 0;

    repeat (3) scen_load_branch();
    to_drive(); clear_in();
    to_check();
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stalls", int'(stall_cycles), 6);
    chk("perf_flushes", int'(flush_count), 3);
`endif

    // load-use: exactly one stall
    to_drive(); clear_in(); ID_EX_MemRead = 1; ID_EX_WriteReg = 8; IF_ID_RegisterRs = 8;
    to_check(); chk("lu_stall", int'(stall_active), 1);
    chk("lu_ifw", int'(IF_ID_Write), 0);
    to_drive(); clear_in(); IF_ID_RegisterRs = 8;
    to_check(); chk("lu_after", int'(PCWrite), 1);

    // ALU result feeding bne
    to_drive(); clear_in(); ID_EX_RegWrite = 1; ID_EX_WriteReg = 11;
    bne = 1; IF_ID_RegisterRs = 11; IF_ID_RegisterRt = 12; IF_ID_UsesRt = 1; branch_taken = 1;
    to_check(); chk("ba_stall", int'(stall_active), 1);
    chk("ba_noflush", int'(IF_ID_Flush), 0);
    to_drive(); ID_EX_RegWrite = 0;
    to_check(); chk("ba_flush", int'(IF_ID_Flush), 1);
    chk("ba_pcwrite", int'(PCWrite), 1);

    // $zero never matches; jump flushes without stalling
    to_drive(); clear_in(); ID_EX_MemRead = 1; ID_EX_WriteReg = 0; IF_ID_RegisterRs = 0;
    to_check(); chk("r0_nostall", int'(stall_active), 0);
    to_drive(); jump = 1;
    to_check(); chk("jump_flush", int'(IF_ID_Flush), 1);
    chk("jump_nostall", int'(PCWrite), 1);

    // reset during the STALL state
    to_drive(); load_branch();
    to_check(); chk("rs_stall", int'(stall_active), 1);
    to_drive(); rst = 1;
    to_check(); chk("rs_abort", int'(stall_active), 0);
    chk("rs_bubble", int'(ID_EX_Bubble), 1);
    to_drive(); rst = 0; clear_in();
    to_check(); chk("rs_run", int'(PCWrite), 1);
    chk("rs_nostall", int'(stall_active), 0);

    for (int i = 0; i < 3000; i++) begin
      to_drive();
      rst              = ($urandom_range(0, 59) == 0);
      ID_EX_MemRead    = 1'($urandom_range(0, 1));
      ID_EX_RegWrite   = 1'($urandom_range(0, 1));
      ID_EX_WriteReg   = 5'($urandom_range(0, 3));
      EX_MEM_MemRead   = 1'($urandom_range(0, 1));
      EX_MEM_WriteReg  = 5'($urandom_range(0, 3));
      IF_ID_RegisterRs = 5'($urandom_range(0, 3));
      IF_ID_RegisterRt = 5'($urandom_range(0, 3));
      IF_ID_UsesRt     = 1'($urandom_range(0, 1));
      beq              = ($urandom_range(0, 2) == 0);
      bne              = ($urandom_range(0, 3) == 0);
      branch_taken     = 1'($urandom_range(0, 1));
      jump             = ($urandom_range(0, 4) == 0);
    end
    to_drive(); rst = 0; clear_in();
    to_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
